// File: rtl/loom_dfx_quiesce.sv
// ---------------------------------------------------------------------------
// loom_dfx_quiesce
//
// Quiesce controller for a DFX decoupler. It sits in the static region. It
// watches the AXI-Lite (interface 0) and AXI4 (interface 1) handshakes that
// cross into the reconfigurable partition and keeps a count of outstanding
// transactions. When software asks for a decouple, the controller blocks new
// requests from the static masters. It then waits for all in-flight traffic
// to finish before it raises the decoupler's decouple input. This keeps any
// transaction from being split across a reconfiguration.
//
// Parameters
//   CNT_W          width of each outstanding-transaction counter
//   TIMEOUT_CYCLES drain cycles allowed before decouple is forced (>= 1)
//   SETTLE_CYCLES  cycles to wait after decouple_status falls (0 allowed)
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_decouple_i      software level request, 1 = decouple the RP
//   decouple_o          to the decoupler's decouple input
//   decouple_status_i   from the decoupler's decouple_status output
//   block_o             to static masters: issue no new AW/AR/W while 1
//   done_o              decoupled and the decoupler confirms it
//   busy_o              in BLOCK, DRAIN or RECOUPLE
//   timeout_o           sticky: the last drain timed out
//   err_o               sticky until reset: a counter underflowed/saturated
//   i0_*                interface-0 (AXI-Lite) handshake snoop
//   i1_*                interface-1 (AXI4) handshake snoop, with wlast/rlast
// ---------------------------------------------------------------------------
module loom_dfx_quiesce #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_decouple_i,
  output logic decouple_o,
  input  logic decouple_status_i,
  output logic block_o,
  output logic done_o,
  output logic busy_o,
  output logic timeout_o,
  output logic err_o,
  input  logic i0_awvalid,
  input  logic i0_awready,
  input  logic i0_wvalid,
  input  logic i0_wready,
  input  logic i0_bvalid,
  input  logic i0_bready,
  input  logic i0_arvalid,
  input  logic i0_arready,
  input  logic i0_rvalid,
  input  logic i0_rready,
  input  logic i1_awvalid,
  input  logic i1_awready,
  input  logic i1_wvalid,
  input  logic i1_wready,
  input  logic i1_bvalid,
  input  logic i1_bready,
  input  logic i1_arvalid,
  input  logic i1_arready,
  input  logic i1_rvalid,
  input  logic i1_rready,
  input  logic i1_wlast,
  input  logic i1_rlast
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STL_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_COUPLED,
    ST_BLOCK,
    ST_DRAIN,
    ST_DECOUPLED,
    ST_RECOUPLE
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [STL_W-1:0]  settle_q, settle_d;
  logic              timeout_hit;
  logic              drain_start;

  logic              decouple_q, decouple_d;
  logic              block_q, block_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;

  // Counter slots: 0 i0 AW, 1 i0 last-W, 2 i0 AR, 3 i1 AW, 4 i1 last-W, 5 i1 AR
  logic [5:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]            cnt_inc;
  logic [5:0]            cnt_dec;
  logic                  cnt_en;
  logic                  cnt_err;
  logic                  drained;

  // Handshake detection. On AXI-Lite every W and R beat is a last beat.
  logic i0_aw_hs, i0_wl_hs, i0_b_hs, i0_ar_hs, i0_rl_hs;
  logic i1_aw_hs, i1_wl_hs, i1_b_hs, i1_ar_hs, i1_rl_hs;

  assign i0_aw_hs = i0_awvalid & i0_awready;
  assign i0_wl_hs = i0_wvalid  & i0_wready;
  assign i0_b_hs  = i0_bvalid  & i0_bready;
  assign i0_ar_hs = i0_arvalid & i0_arready;
  assign i0_rl_hs = i0_rvalid  & i0_rready;

  assign i1_aw_hs = i1_awvalid & i1_awready;
  assign i1_wl_hs = i1_wvalid  & i1_wready & i1_wlast;
  assign i1_b_hs  = i1_bvalid  & i1_bready;
  assign i1_ar_hs = i1_arvalid & i1_arready;
  assign i1_rl_hs = i1_rvalid  & i1_rready & i1_rlast;

  assign cnt_inc = {i1_ar_hs, i1_wl_hs, i1_aw_hs, i0_ar_hs, i0_wl_hs, i0_aw_hs};
  assign cnt_dec = {i1_rl_hs, i1_b_hs,  i1_b_hs,  i0_rl_hs, i0_b_hs,  i0_b_hs};

  // While decoupled, the decoupler answers on behalf of the RP. Its absorbed
  // responses do not belong to any tracked transaction, so counting stops.
  assign cnt_en  = ~(decouple_q | decouple_status_i);
  assign drained = (cnt_q == '0);

  // Counter next-state logic. A coincident increment and decrement cancel.
  // An underflow or saturation holds the count and raises the sticky error.
  // A forced (timed-out) decouple discards all history.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cnt_en && cnt_inc[k] && !cnt_dec[k]) begin
        if (&cnt_q[k]) begin
          cnt_err = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end else if (cnt_en && cnt_dec[k] && !cnt_inc[k]) begin
        if (cnt_q[k] == '0) begin
          cnt_err = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
    end
    if (timeout_hit) begin
      cnt_d = '0;
    end
  end

  // Outstanding-transaction counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // State register, plus the drain/settle timers and the registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_COUPLED;
      timer_q    <= '0;
      settle_q   <= '0;
      decouple_q <= 1'b0;
      block_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      settle_q   <= settle_d;
      decouple_q <= decouple_d;
      block_q    <= block_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. BLOCK always lasts one cycle, so a handshake that
  // coincides with the rise of block_o is still counted before the drain
  // check. DRAIN priority: abort, then drained, then timeout. Once RECOUPLE
  // sees status low, it runs the settle count to completion. It ignores any
  // new request until it is back in COUPLED.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    settle_d    = settle_q;
    timeout_hit = 1'b0;
    drain_start = 1'b0;
    case (state_q)
      ST_COUPLED: begin
        if (req_decouple_i) begin
          state_d = ST_BLOCK;
        end
      end
      ST_BLOCK: begin
        if (!req_decouple_i) begin
          state_d = ST_COUPLED;
        end else begin
          state_d     = ST_DRAIN;
          timer_d     = '0;
          drain_start = 1'b1;
        end
      end
      ST_DRAIN: begin
        timer_d = timer_q + TMR_W'(1);
        if (!req_decouple_i) begin
          state_d = ST_COUPLED;
        end else if (drained) begin
          state_d = ST_DECOUPLED;
        end else if (timer_q == TMR_LAST) begin
          state_d     = ST_DECOUPLED;
          timeout_hit = 1'b1;
        end
      end
      ST_DECOUPLED: begin
        if (!req_decouple_i) begin
          state_d  = ST_RECOUPLE;
          settle_d = '0;
        end
      end
      ST_RECOUPLE: begin
        if (!decouple_status_i || settle_q != '0) begin
          if (settle_q == STL_LAST) begin
            state_d = ST_COUPLED;
          end else begin
            settle_d = settle_q + STL_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_COUPLED;
      end
    endcase
  end

  // Output logic. Outputs are computed from the next state and registered,
  // so each output flop matches the state register cycle for cycle.
  always_comb begin
    decouple_d = (state_d == ST_DECOUPLED);
    block_d    = (state_d != ST_COUPLED);
    busy_d     = (state_d == ST_BLOCK) || (state_d == ST_DRAIN) ||
                 (state_d == ST_RECOUPLE);
    done_d     = (state_d == ST_DECOUPLED) && decouple_status_i;
    timeout_d  = timeout_q;
    if (drain_start) begin
      timeout_d = 1'b0;
    end
    if (timeout_hit) begin
      timeout_d = 1'b1;
    end
    err_d      = err_q | cnt_err;
  end

  assign decouple_o = decouple_q;
  assign block_o    = block_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_loom_dfx_quiesce.sv
// Bench for loom_dfx_quiesce. Stimulus runs as one linear directed sequence.
// Each step pushes its expected result to a scoreboard queue. The result is
// popped and compared when the DUT output is sampled on the falling edge.
// The output vector packs {decouple, block, done, busy, timeout, err} from
// MSB to LSB.
module tb_loom_dfx_quiesce;

  localparam int V_IDLE = 6'b000000;
  localparam int V_BUSY = 6'b010100;
  localparam int V_DEC  = 6'b110000;
  localparam int V_DONE = 6'b111000;
  localparam int V_ERR  = 6'b000001;

  logic       clk_i;
  logic       rst_i;
  logic       reqDecouple;
  logic       loopback;
  logic       statusManual;
  logic       statusWire;
  logic [4:0] i0Valid, i0Ready, i1Valid, i1Ready;
  logic       i1Last;
  logic       decouple_o, block_o, done_o, busy_o, timeout_o, err_o;

  typedef struct {
    string tag;
    int    value;
  } expItem_t;

  expItem_t expQ[$];
  int       cmpCount;
  int       mismatchCount;
  int       n;

  // Status either loops back from decouple_o or is driven by hand
  assign statusWire = loopback ? decouple_o : statusManual;

  loom_dfx_quiesce #(
    .CNT_W(3),
    .TIMEOUT_CYCLES(16),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_decouple_i(reqDecouple),
    .decouple_o(decouple_o),
    .decouple_status_i(statusWire),
    .block_o(block_o),
    .done_o(done_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o),
    .err_o(err_o),
    .i0_awvalid(i0Valid[4]), .i0_awready(i0Ready[4]),
    .i0_wvalid(i0Valid[3]),  .i0_wready(i0Ready[3]),
    .i0_bvalid(i0Valid[2]),  .i0_bready(i0Ready[2]),
    .i0_arvalid(i0Valid[1]), .i0_arready(i0Ready[1]),
    .i0_rvalid(i0Valid[0]),  .i0_rready(i0Ready[0]),
    .i1_awvalid(i1Valid[4]), .i1_awready(i1Ready[4]),
    .i1_wvalid(i1Valid[3]),  .i1_wready(i1Ready[3]),
    .i1_bvalid(i1Valid[2]),  .i1_bready(i1Ready[2]),
    .i1_arvalid(i1Valid[1]), .i1_arready(i1Ready[1]),
    .i1_rvalid(i1Valid[0]),  .i1_rready(i1Ready[0]),
    .i1_wlast(i1Last),
    .i1_rlast(i1Last)
  );

  // Free-running clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int outs();
    return {26'd0, decouple_o, block_o, done_o, busy_o, timeout_o, err_o};
  endfunction

  task automatic pushExp(input string tag, input int value);
    expItem_t e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input int observed);
    expItem_t e;
    cmpCount++;
    if (expQ.size() == 0) begin
      mismatchCount++;
      $error("[TB] FAIL scoreboardEmpty observed=%0d expected=none", observed);
    end else begin
      e = expQ.pop_front();
      assert (observed === e.value) else begin
        mismatchCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
      end
    end
  endtask

  // One clock step with the given request and handshake pulses (valid=ready)
  task automatic applyStimulus(input string tag, input logic req,
                               input logic [4:0] hs0, input logic [4:0] hs1,
                               input logic last, input int expVec);
    reqDecouple = req;
    i0Valid = hs0;
    i0Ready = hs0;
    i1Valid = hs1;
    i1Ready = hs1;
    i1Last  = last;
    pushExp(tag, expVec);
    @(negedge clk_i);
    i0Valid = '0;
    i0Ready = '0;
    i1Valid = '0;
    i1Ready = '0;
    i1Last  = 1'b0;
    checkOutput(outs());
  endtask

  // Bounded wait: which=0 watches decouple_o, which=1 watches block_o
  task automatic countUntil(input int which, input logic level, output int cycles);
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (((which == 0) ? decouple_o : block_o) == level) begin
        cycles = c;
        break;
      end
    end
  endtask

  // With status looped back, block_o falls 6 edges after req drops
  task automatic recouple(input string tag);
    int cyc;
    pushExp(tag, 6);
    reqDecouple = 1'b0;
    countUntil(1, 1'b0, cyc);
    checkOutput(cyc);
  endtask

  task automatic pulseReset();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    cmpCount      = 0;
    mismatchCount = 0;
    rst_i         = 1'b1;
    reqDecouple   = 1'b0;
    loopback      = 1'b1;
    statusManual  = 1'b0;
    i0Valid = '0; i0Ready = '0; i1Valid = '0; i1Ready = '0; i1Last = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    pushExp("reset", V_IDLE);
    checkOutput(outs());

    // Idle decouple, with the decoupler's absorbed B ignored while decoupled
    applyStimulus("idleBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("idleDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("idleDecouple", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    applyStimulus("idleDone", 1'b1, 5'b0, 5'b0, 1'b0, V_DONE);
    applyStimulus("ignoreWhileDecoupled", 1'b1, 5'b0, 5'b00100, 1'b0, V_DONE);

    // Manual recouple with a delayed status release and an early re-request
    statusManual = 1'b1;
    loopback     = 1'b0;
    applyStimulus("rcEnter", 1'b0, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rcStatusHigh", 1'b0, 5'b0, 5'b0, 1'b0, V_BUSY);
    statusManual = 1'b0;
    applyStimulus("rcSettle1", 1'b0, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rcSettle2", 1'b0, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rcReqIgnored3", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rcReqIgnored4", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rcCoupled", 1'b1, 5'b0, 5'b0, 1'b0, V_IDLE);
    applyStimulus("rcReqTakesEffect", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("abortInBlock", 1'b0, 5'b0, 5'b0, 1'b0, V_IDLE);
    loopback = 1'b1;

    // Outstanding drain: 3 i1 reads, 3 bursts of 4 beats with rlast on beat 4
    for (int k = 0; k < 3; k++)
      applyStimulus("i1Ar", 1'b0, 5'b0, 5'b00010, 1'b0, V_IDLE);
    applyStimulus("rdBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rdDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    for (int b = 1; b <= 12; b++)
      applyStimulus("rdBeat", 1'b1, 5'b0, 5'b00001, (b % 4) == 0, V_BUSY);
    applyStimulus("rdDecouple", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    applyStimulus("rdDone", 1'b1, 5'b0, 5'b0, 1'b0, V_DONE);
    recouple("rdRecouple");

    // Write ordering on i0: W at t, req at t+1, AW at t+2, B at t+5
    applyStimulus("woW", 1'b0, 5'b01000, 5'b0, 1'b0, V_IDLE);
    applyStimulus("woReq", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("woAw", 1'b1, 5'b10000, 5'b0, 1'b0, V_BUSY);
    applyStimulus("woWait3", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("woWait4", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("woB", 1'b1, 5'b00100, 5'b0, 1'b0, V_BUSY);
    applyStimulus("woDecouple", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    recouple("woRecouple");

    // Simultaneous AW and B on i0 leave the AW count unchanged
    applyStimulus("simAw", 1'b0, 5'b10000, 5'b0, 1'b0, V_IDLE);
    applyStimulus("simW", 1'b0, 5'b01000, 5'b0, 1'b0, V_IDLE);
    applyStimulus("simAwB", 1'b0, 5'b10100, 5'b0, 1'b0, V_IDLE);
    applyStimulus("simW2", 1'b0, 5'b01000, 5'b0, 1'b0, V_IDLE);
    applyStimulus("simBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("simDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("simLastB", 1'b1, 5'b00100, 5'b0, 1'b0, V_BUSY);
    applyStimulus("simDecouple", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    recouple("simRecouple");

    // Timeout: one i1 AW never answered
    applyStimulus("toAw", 1'b0, 5'b0, 5'b10000, 1'b0, V_IDLE);
    applyStimulus("toBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("toDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    pushExp("toLatency", 16);
    countUntil(0, 1'b1, n);
    checkOutput(n);
    pushExp("toFlags", 6'b110010);
    checkOutput(outs());
    applyStimulus("toDone", 1'b1, 5'b0, 5'b0, 1'b0, 6'b111010);
    recouple("toRecouple");
    applyStimulus("toSticky", 1'b0, 5'b0, 5'b0, 1'b0, 6'b000010);
    applyStimulus("toReBlock", 1'b1, 5'b0, 5'b0, 1'b0, 6'b010110);
    applyStimulus("toClearOnDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("toCountersZeroed", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    recouple("toRecouple2");

    // Abort during DRAIN with an i0 read outstanding
    applyStimulus("abAr", 1'b0, 5'b00010, 5'b0, 1'b0, V_IDLE);
    applyStimulus("abBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("abDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("abDrainHold", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("abAbort", 1'b0, 5'b0, 5'b0, 1'b0, V_IDLE);
    applyStimulus("abStayCoupled", 1'b0, 5'b0, 5'b0, 1'b0, V_IDLE);
    applyStimulus("abR", 1'b0, 5'b00001, 5'b0, 1'b0, V_IDLE);

    // Asynchronous reset while DECOUPLED
    applyStimulus("rsBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rsDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("rsDecouple", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    #2;
    rst_i = 1'b1;
    #1;
    pushExp("asyncReset", V_IDLE);
    checkOutput(outs());
    reqDecouple = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset discards an outstanding i1 read
    applyStimulus("histAr", 1'b0, 5'b0, 5'b00010, 1'b0, V_IDLE);
    pulseReset();
    applyStimulus("histBlock", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("histDrain", 1'b1, 5'b0, 5'b0, 1'b0, V_BUSY);
    applyStimulus("histCleared", 1'b1, 5'b0, 5'b0, 1'b0, V_DEC);
    recouple("histRecouple");

    // Saturation of a 3-bit counter, then B underflow
    for (int k = 0; k < 7; k++)
      applyStimulus("satFill", 1'b0, 5'b00010, 5'b0, 1'b0, V_IDLE);
    applyStimulus("saturate", 1'b0, 5'b00010, 5'b0, 1'b0, V_ERR);
    pulseReset();
    pushExp("errResetClears", V_IDLE);
    checkOutput(outs());
    applyStimulus("underflowB", 1'b0, 5'b00100, 5'b0, 1'b0, V_ERR);
    applyStimulus("errSticky", 1'b0, 5'b0, 5'b0, 1'b0, V_ERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, mismatchCount);
    $finish;
  end

endmodule
